// File: rtl/guess_checker.sv
// Guess checker: latches an LFSR-derived BCD secret on new_game, grades BCD guesses,
// counts attempts and ends the game on a win or when attempts run out.
module guess_checker #(
  parameter int unsigned MAX_ATTEMPTS = 10,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       new_game,
  input  logic [1:0] max_digits,
  input  logic       submit,
  input  logic [3:0] guess_digit_1,
  input  logic [3:0] guess_digit_2,
  input  logic [3:0] guess_digit_3,
  output logic [3:0] secret_digit_1,
  output logic [3:0] secret_digit_2,
  output logic [3:0] secret_digit_3,
  output logic [1:0] result,
  output logic [3:0] attempts,
  output logic       win,
  output logic       game_over
);

  localparam logic [3:0] MaxAtt = 4'(MAX_ATTEMPTS);

  localparam logic [1:0] ResNone = 2'b00;
  localparam logic [1:0] ResLow  = 2'b01;
  localparam logic [1:0] ResHigh = 2'b10;
  localparam logic [1:0] ResOk   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    WIN,
    LOSE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        submit_q;
  logic [1:0]  nd_q, nd_d;
  logic [3:0]  s1_q, s1_d;
  logic [3:0]  s2_q, s2_d;
  logic [3:0]  s3_q, s3_d;
  logic [1:0]  res_q, res_d;
  logic [3:0]  att_q, att_d;

  logic        sub_edge;
  logic [1:0]  nd_in;
  logic        g2_act;
  logic        g3_act;
  logic        g_valid;
  logic [11:0] guess_w;
  logic [11:0] secret_w;
  logic [3:0]  att_inc;

  function automatic logic [3:0] fold(input logic [3:0] n);
    return (n > 4'd9) ? (n - 4'd10) : n;
  endfunction

  assign sub_edge = submit & ~submit_q;
  assign nd_in    = (max_digits == 2'd0) ? 2'd1 : max_digits;
  assign g2_act   = (nd_q >= 2'd2);
  assign g3_act   = (nd_q == 2'd3);

  // Inactive digits never invalidate a guess and compare as zero.
  assign g_valid = (guess_digit_1 <= 4'd9)
                && (!g2_act || (guess_digit_2 <= 4'd9))
                && (!g3_act || (guess_digit_3 <= 4'd9));

  // Digits are all <= 9, so the packed BCD word orders like the number.
  assign guess_w = {g3_act ? guess_digit_3 : 4'd0,
                    g2_act ? guess_digit_2 : 4'd0,
                    guess_digit_1};
  assign secret_w = {s3_q, s2_q, s1_q};
  assign att_inc  = att_q + 4'd1;

  assign lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d = state_q;
    nd_d    = nd_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    res_d   = res_q;
    att_d   = att_q;
    if (new_game) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        LOAD: begin
          nd_d    = nd_in;
          s1_d    = fold(lfsr_q[3:0]);
          s2_d    = (nd_in >= 2'd2) ? fold(lfsr_q[7:4]) : 4'd0;
          s3_d    = (nd_in == 2'd3) ? fold(lfsr_q[11:8]) : 4'd0;
          att_d   = 4'd0;
          res_d   = ResNone;
          state_d = PLAY;
        end
        PLAY: begin
          if (sub_edge && g_valid) begin
            att_d = att_inc;
            if (guess_w == secret_w) begin
              res_d   = ResOk;
              state_d = WIN;
            end else begin
              res_d = (guess_w < secret_w) ? ResLow : ResHigh;
              if (att_inc == MaxAtt) state_d = LOSE;
            end
          end
        end
        IDLE, WIN, LOSE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      submit_q <= 1'b0;
      nd_q     <= 2'd1;
      s1_q     <= 4'd0;
      s2_q     <= 4'd0;
      s3_q     <= 4'd0;
      res_q    <= ResNone;
      att_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      submit_q <= submit;
      nd_q     <= nd_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      res_q    <= res_d;
      att_q    <= att_d;
    end
  end

  assign secret_digit_1 = s1_q;
  assign secret_digit_2 = s2_q;
  assign secret_digit_3 = s3_q;
  assign result         = res_q;
  assign attempts       = att_q;
  assign win            = (state_q == WIN);
  assign game_over      = (state_q == WIN) || (state_q == LOSE);

endmodule

// File: tb/tb_guess_checker.sv
// Testbench for guess_checker: table of single-guess games plus
// hand-written multi-cycle sequences, checked against a small scoreboard.
module tb_guess_checker;

  localparam int MAXA = 3;

  logic       clk = 1'b0;
  logic       restart;
  logic       new_game;
  logic [1:0] max_digits;
  logic       submit;
  logic [3:0] gd1, gd2, gd3;
  logic [3:0] sd1, sd2, sd3;
  logic [1:0] result;
  logic [3:0] attempts;
  logic       win;
  logic       game_over;

  always #5 clk = ~clk;

  guess_checker #(
    .MAX_ATTEMPTS(MAXA),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .restart(restart),
    .new_game(new_game),
    .max_digits(max_digits),
    .submit(submit),
    .guess_digit_1(gd1),
    .guess_digit_2(gd2),
    .guess_digit_3(gd3),
    .secret_digit_1(sd1),
    .secret_digit_2(sd2),
    .secret_digit_3(sd3),
    .result(result),
    .attempts(attempts),
    .win(win),
    .game_over(game_over)
  );

  // Reference secret generator: Fibonacci LFSR, taps 16,14,13,11.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge restart) begin
    if (restart) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0],
                    m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int n_chk = 0;
  int n_fail = 0;

  int e_s1, e_s2, e_s3, e_res, e_att, e_win, e_go, e_nd;
  bit in_play;

  typedef struct {
    logic [1:0] nd;
    logic [3:0] g3, g2, g1;
    int         acc;
  } vec_t;

  vec_t tbl[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(string nm);
    chk({nm, "_s1"}, 16'(sd1), 16'(e_s1));
    chk({nm, "_s2"}, 16'(sd2), 16'(e_s2));
    chk({nm, "_s3"}, 16'(sd3), 16'(e_s3));
    chk({nm, "_res"}, 16'(result), 16'(e_res));
    chk({nm, "_att"}, 16'(attempts), 16'(e_att));
    chk({nm, "_win"}, 16'(win), 16'(e_win));
    chk({nm, "_go"}, 16'(game_over), 16'(e_go));
  endtask

  function automatic int fold(int n);
    return (n > 9) ? n - 10 : n;
  endfunction

  function automatic int bval(int a3, int a2, int a1, int nd);
    int v;
    v = a1;
    if (nd >= 2) v += a2 * 10;
    if (nd >= 3) v += a3 * 100;
    return v;
  endfunction

  task automatic sb_clear();
    e_s1 = 0; e_s2 = 0; e_s3 = 0;
    e_res = 0; e_att = 0; e_win = 0; e_go = 0;
    in_play = 0;
  endtask

  task automatic sb_guess(int g3, int g2, int g1);
    int gv, sv;
    if (!in_play || e_go != 0) return;
    if (g1 > 9 || (e_nd >= 2 && g2 > 9) || (e_nd >= 3 && g3 > 9)) return;
    e_att++;
    gv = bval(g3, g2, g1, e_nd);
    sv = bval(e_s3, e_s2, e_s1, 3);
    if (gv == sv) begin
      e_res = 3; e_win = 1; e_go = 1;
    end else begin
      e_res = (gv < sv) ? 1 : 2;
      if (e_att == MAXA) e_go = 1;
    end
  endtask

  task automatic start_game(int nd, string nm);
    logic [15:0] cap;
    max_digits = 2'(nd);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    cap = m_lfsr;
    step();
    e_nd = (nd == 0) ? 1 : nd;
    e_s1 = fold(int'(cap[3:0]));
    e_s2 = (e_nd >= 2) ? fold(int'(cap[7:4])) : 0;
    e_s3 = (e_nd >= 3) ? fold(int'(cap[11:8])) : 0;
    e_res = 0; e_att = 0; e_win = 0; e_go = 0;
    in_play = 1;
    check_all(nm);
  endtask

  task automatic guess(int g3, int g2, int g1, string nm);
    gd3 = 4'(g3);
    gd2 = 4'(g2);
    gd1 = 4'(g1);
    submit = 1'b1;
    step();
    submit = 1'b0;
    sb_guess(g3, g2, g1);
    step();
    check_all(nm);
  endtask

  initial begin
    int s, sv, w;
    tbl[0]  = '{nd: 2'd3, g3: 4'd9, g2: 4'd9, g1: 4'd9, acc: 1};
    tbl[1]  = '{nd: 2'd3, g3: 4'd0, g2: 4'd0, g1: 4'd0, acc: 1};
    tbl[2]  = '{nd: 2'd3, g3: 4'hB, g2: 4'd0, g1: 4'd0, acc: 0};
    tbl[3]  = '{nd: 2'd3, g3: 4'd5, g2: 4'hA, g1: 4'd0, acc: 0};
    tbl[4]  = '{nd: 2'd1, g3: 4'd7, g2: 4'd7, g1: 4'd3, acc: 1};
    tbl[5]  = '{nd: 2'd1, g3: 4'hF, g2: 4'hF, g1: 4'd5, acc: 1};
    tbl[6]  = '{nd: 2'd2, g3: 4'hC, g2: 4'd4, g1: 4'd4, acc: 1};
    tbl[7]  = '{nd: 2'd0, g3: 4'd9, g2: 4'd9, g1: 4'd2, acc: 1};
    tbl[8]  = '{nd: 2'd2, g3: 4'd1, g2: 4'hA, g1: 4'd3, acc: 0};
    tbl[9]  = '{nd: 2'd1, g3: 4'd0, g2: 4'd0, g1: 4'hA, acc: 0};
    tbl[10] = '{nd: 2'd3, g3: 4'd5, g2: 4'd5, g1: 4'd5, acc: 1};
    tbl[11] = '{nd: 2'd2, g3: 4'd0, g2: 4'd9, g1: 4'd9, acc: 1};

    restart = 1'b1;
    new_game = 1'b0;
    max_digits = 2'd1;
    submit = 1'b0;
    gd1 = 4'd0; gd2 = 4'd0; gd3 = 4'd0;
    sb_clear();
    e_nd = 1;
    step();
    check_all("reset");
    restart = 1'b0;
    step();

    // Submits in IDLE are ignored
    for (int i = 0; i < 3; i++) guess(0, 0, i + 1, "idle_sub");

    // Single-digit win on second attempt, then extra submit ignored
    start_game(1, "g1_load");
    s = e_s1;
    guess(0, 0, (s + 1) % 10, "g1_wrong");
    guess(0, 0, s, "g1_right");
    chk("g1_win_att", 16'(attempts), 16'd2);
    guess(0, 0, (s + 3) % 10, "g1_after_win");

    // Table of single-guess games
    foreach (tbl[i]) begin
      start_game(int'(tbl[i].nd), $sformatf("v%0d_load", i));
      guess(int'(tbl[i].g3), int'(tbl[i].g2), int'(tbl[i].g1),
            $sformatf("v%0d_guess", i));
      chk($sformatf("v%0d_acc", i), 16'(attempts), 16'(tbl[i].acc));
    end

    // Three-digit game: high, low, invalid hundreds ignored
    start_game(3, "g3_load");
    guess(9, 9, 9, "g3_999");
    guess(0, 0, 0, "g3_000");
    guess(11, 0, 0, "g3_inv");

    // Exhaust attempts with wrong two-digit guesses
    start_game(2, "lose_load");
    sv = bval(e_s3, e_s2, e_s1, 3);
    for (int i = 0; i < 3; i++) begin
      w = (sv + 1 + i) % 100;
      guess(0, w / 10, w % 10, $sformatf("lose_w%0d", i));
    end
    chk("lose_go", 16'(game_over), 16'd1);
    chk("lose_win", 16'(win), 16'd0);
    chk("lose_att", 16'(attempts), 16'(MAXA));
    guess(0, w / 10, w % 10, "lose_extra");

    // Held submit counts once; tens digit ignored with one active digit
    start_game(1, "hold_load");
    s = e_s1;
    gd3 = 4'd0; gd2 = 4'd0; gd1 = 4'((s + 1) % 10);
    submit = 1'b1;
    repeat (10) step();
    submit = 1'b0;
    sb_guess(0, 0, (s + 1) % 10);
    step();
    check_all("hold");
    chk("hold_att", 16'(attempts), 16'd1);
    guess(0, 7, s, "nd1_tens7");

    // Asynchronous restart between clock edges
    start_game(3, "rst_load");
    sv = bval(e_s3, e_s2, e_s1, 3);
    w = (sv + 1) % 1000;
    guess(w / 100, (w / 10) % 10, w % 10, "rst_pre");
    #3;
    restart = 1'b1;
    #1;
    sb_clear();
    check_all("async_rst");
    step();
    restart = 1'b0;
    step();
    guess(0, 0, 1, "rst_idle");

    // new_game after two attempts clears the game
    start_game(3, "ng_load");
    sv = bval(e_s3, e_s2, e_s1, 3);
    for (int i = 0; i < 2; i++) begin
      w = (sv + 1 + i) % 1000;
      guess(w / 100, (w / 10) % 10, w % 10, $sformatf("ng_w%0d", i));
    end
    chk("ng_att2", 16'(attempts), 16'd2);
    start_game(3, "ng_reload");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
